// File: rtl/i2s_transmitter.sv
// I2S transmitter: buffers stereo 16-bit pairs in a small FIFO and serialises one pair per
// 64-bclk frame (left slot on lrclk=0, right on lrclk=1), MSB first with the one-bclk delay.
module i2s_transmitter #(
    parameter int BCLK_DIV   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          sample_valid_in,
    input  logic [15:0]                   left_in,
    input  logic [15:0]                   right_in,
    input  logic                          clear_flags_in,
    output logic                          i2s_bclk_out,
    output logic                          i2s_lrclk_out,
    output logic                          i2s_data_out,
    output logic                          frame_start_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          underflow_out,
    output logic                          overflow_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } pair_t;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       next_bit;
    logic             fall_tick;
    logic             boundary;
    logic             do_pop;
    logic             do_push;
    logic [15:0]      left_sr;
    logic [15:0]      right_sr;
    pair_t            mem [FIFO_DEPTH];
    pair_t            head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        fall_tick = 1'b0;
        next_bit  = bit_cnt + 6'd1;
        boundary  = 1'b0;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        head      = mem[rd_ptr];

        fall_tick = (div_cnt == DIV_W'(BCLK_DIV - 1)) && i2s_bclk_out;
        boundary  = fall_tick && (next_bit == 6'd0);
        do_pop    = boundary && (count != '0);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        do_push   = sample_valid_in && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    end

    // NOTE: FIFO storage has no reset; the pointers and count define what is valid, and this keeps it RAM-inferable.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= '{left: left_in, right: right_in};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_cnt      <= '0;
            i2s_bclk_out <= 1'b0;
        end else if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
            div_cnt      <= '0;
            i2s_bclk_out <= ~i2s_bclk_out;
        end else begin
            div_cnt      <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bit_cnt         <= 6'd63;
            i2s_lrclk_out   <= 1'b0;
            i2s_data_out    <= 1'b0;
            frame_start_out <= 1'b0;
            left_sr         <= '0;
            right_sr        <= '0;
        end else begin
            frame_start_out <= boundary;
            if (fall_tick) begin
                bit_cnt       <= next_bit;
                i2s_lrclk_out <= next_bit[5];
                if (next_bit == 6'd0) begin
                    i2s_data_out <= 1'b0;
                    left_sr      <= do_pop ? head.left  : 16'd0;
                    right_sr     <= do_pop ? head.right : 16'd0;
                end else if ((next_bit[4:0] != 5'd0) && (next_bit[4:0] <= 5'd16)) begin
                    if (!next_bit[5]) begin
                        i2s_data_out <= left_sr[15];
                        left_sr      <= {left_sr[14:0], 1'b0};
                    end else begin
                        i2s_data_out <= right_sr[15];
                        right_sr     <= {right_sr[14:0], 1'b0};
                    end
                end else begin
                    i2s_data_out <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A flag-setting event outranks a clear in the same cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            underflow_out <= 1'b0;
            overflow_out  <= 1'b0;
        end else begin
            if (boundary && (count == '0)) underflow_out <= 1'b1;
            else if (clear_flags_in)       underflow_out <= 1'b0;

            if (sample_valid_in && !do_push) overflow_out <= 1'b1;
            else if (clear_flags_in)         overflow_out <= 1'b0;
        end
    end

    assign fifo_count_out = count;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: decodes serial frames at bclk rising edges and checks
// words, lrclk, timing, FIFO ordering, flags and reset behaviour against hand-computed values.
module tb_i2s_transmitter;

    localparam int BCLK_DIV   = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 64 * 2 * BCLK_DIV;

    logic        clk_in;
    logic        rst_in;
    logic        sample_valid_in;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        clear_flags_in;
    logic        i2s_bclk_out;
    logic        i2s_lrclk_out;
    logic        i2s_data_out;
    logic        frame_start_out;
    logic [2:0]  fifo_count_out;
    logic        underflow_out;
    logic        overflow_out;

    int vectors;
    int miscompares;
    int since_fs;

    i2s_transmitter #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .clear_flags_in  (clear_flags_in),
        .i2s_bclk_out    (i2s_bclk_out),
        .i2s_lrclk_out   (i2s_lrclk_out),
        .i2s_data_out    (i2s_data_out),
        .frame_start_out (frame_start_out),
        .fifo_count_out  (fifo_count_out),
        .underflow_out   (underflow_out),
        .overflow_out    (overflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance to the next falling clk edge; since_fs counts cycles since the last frame_start.
    task automatic step();
        @(negedge clk_in);
        if (frame_start_out) since_fs = 0;
        else                 since_fs++;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        sample_valid_in = 1'b1;
        left_in         = l;
        right_in        = r;
        step();
        sample_valid_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags_in = 1'b1;
        step();
        clear_flags_in = 1'b0;
    endtask

    task automatic wait_boundary(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start_out && n < 2000);
        vectors++;
        if (frame_start_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: no frame_start within %0d cycles", name, n);
        end
    endtask

    task automatic go_pre_boundary(input string name);
        int n;
        n = 0;
        while (since_fs != FRAME - 1 && n < 2000) begin
            step();
            n++;
        end
        vectors++;
        if (since_fs != FRAME - 1) begin
            miscompares++;
            $display("FAIL %s: pre-boundary position not reached, since_fs=%0d", name, since_fs);
        end
    endtask

    // Called on the negedge of a boundary; returns on the last cycle before the next boundary.
    task automatic capture_frame(input logic [15:0] exp_l, input logic [15:0] exp_r, input string name);
        logic [63:0] got_data, got_lr, exp_data, exp_lr;
        logic [15:0] w;
        logic        prev_bclk;
        int          rises, p;
        bit          timing_bad;
        got_data   = '0;
        got_lr     = '0;
        rises      = 0;
        timing_bad = 1'b0;
        prev_bclk  = i2s_bclk_out;
        for (int i = 1; i < FRAME; i++) begin
            step();
            if (frame_start_out) timing_bad = 1'b1;
            if (!prev_bclk && i2s_bclk_out) begin
                if (rises < 64) begin
                    if (i != BCLK_DIV + 2 * BCLK_DIV * rises) timing_bad = 1'b1;
                    got_data[rises] = i2s_data_out;
                    got_lr[rises]   = i2s_lrclk_out;
                end
                rises++;
            end
            prev_bclk = i2s_bclk_out;
        end
        for (int k = 0; k < 64; k++) begin
            p           = k % 32;
            w           = (k < 32) ? exp_l : exp_r;
            exp_data[k] = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
            exp_lr[k]   = (k >= 32);
        end
        vectors++;
        if (got_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s data: got %h expected %h", name, got_data, exp_data);
        end
        vectors++;
        if (got_lr !== exp_lr) begin
            miscompares++;
            $display("FAIL %s lrclk: got %h expected %h", name, got_lr, exp_lr);
        end
        vectors++;
        if (rises != 64 || timing_bad) begin
            miscompares++;
            $display("FAIL %s timing: %0d bclk rises (expected 64), misplaced edge=%0d", name, rises, timing_bad);
        end
    endtask

    task automatic test_reset();
        rst_in          = 1'b0;
        sample_valid_in = 1'b0;
        left_in         = '0;
        right_in        = '0;
        clear_flags_in  = 1'b0;
        since_fs        = 0;
        repeat (3) step();
        vectors++;
        if ({i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out, underflow_out, overflow_out} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out, underflow_out, overflow_out});
        end
        vectors++;
        if (fifo_count_out !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", fifo_count_out);
        end
        rst_in = 1'b1;
        push(16'hA5C3, 16'h8001);
        for (int c = 2; c <= 2 * BCLK_DIV; c++) begin
            step();
            if (c == BCLK_DIV - 1) begin
                vectors++;
                if (i2s_bclk_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bclk_before_rise: got %b expected 0", i2s_bclk_out);
                end
            end
            if (c == BCLK_DIV) begin
                vectors++;
                if (i2s_bclk_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_bclk_rise: got %b expected 1", i2s_bclk_out);
                end
            end
            if (c == 2 * BCLK_DIV - 1) begin
                vectors++;
                if (frame_start_out !== 1'b0 || fifo_count_out !== 3'd1) begin
                    miscompares++;
                    $display("FAIL pre_first_boundary: got fs=%b count=%0d expected fs=0 count=1",
                             frame_start_out, fifo_count_out);
                end
            end
            if (c == 2 * BCLK_DIV) begin
                vectors++;
                if (frame_start_out !== 1'b1 || i2s_bclk_out !== 1'b0 || fifo_count_out !== 3'd0) begin
                    miscompares++;
                    $display("FAIL first_boundary: got fs=%b bclk=%b count=%0d expected fs=1 bclk=0 count=0",
                             frame_start_out, i2s_bclk_out, fifo_count_out);
                end
            end
        end
    endtask

    task automatic test_basic_frame();
        capture_frame(16'hA5C3, 16'h8001, "first_frame");
        wait_boundary("second_boundary");
        vectors++;
        if (underflow_out !== 1'b1 || fifo_count_out !== 3'd0) begin
            miscompares++;
            $display("FAIL first_underflow: got uf=%b count=%0d expected uf=1 count=0", underflow_out, fifo_count_out);
        end
    endtask

    task automatic test_underflow();
        capture_frame(16'h0000, 16'h0000, "empty_frame");
    endtask

    task automatic test_clear_flags();
        go_pre_boundary("clear_collision_pos");
        pulse_clear();
        vectors++;
        if (underflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_vs_event: got uf=%b expected 1", underflow_out);
        end
        pulse_clear();
        vectors++;
        if (underflow_out !== 1'b0 || overflow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_flags: got uf=%b of=%b expected 0 0", underflow_out, overflow_out);
        end
    endtask

    task automatic test_overflow();
        for (int n = 1; n <= 5; n++) push(16'(n), 16'hF000 | 16'(n));
        vectors++;
        if (fifo_count_out !== 3'd4 || overflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got count=%0d of=%b expected count=4 of=1", fifo_count_out, overflow_out);
        end
        for (int n = 1; n <= 4; n++) begin
            wait_boundary("overflow_boundary");
            vectors++;
            if (fifo_count_out !== 3'(4 - n)) begin
                miscompares++;
                $display("FAIL overflow_drain_count: got %0d expected %0d", fifo_count_out, 4 - n);
            end
            capture_frame(16'(n), 16'hF000 | 16'(n), "overflow_frame");
        end
        wait_boundary("after_drain");
        vectors++;
        if (underflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_underflow: got %b expected 1", underflow_out);
        end
        capture_frame(16'h0000, 16'h0000, "dropped_fifth");
    endtask

    task automatic test_full_simultaneous();
        logic [15:0] pl [5];
        logic [15:0] pr [5];
        pl = '{16'h1234, 16'h9ABC, 16'h0F0F, 16'h7FFF, 16'hCAFE};
        pr = '{16'h5678, 16'hDEF0, 16'hF0F0, 16'h8000, 16'hBEEF};
        wait_boundary("full_setup");
        pulse_clear();
        for (int k = 0; k < 4; k++) push(pl[k], pr[k]);
        vectors++;
        if (fifo_count_out !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_count: got %0d expected 4", fifo_count_out);
        end
        go_pre_boundary("full_simul_pos");
        push(pl[4], pr[4]);
        vectors++;
        if (fifo_count_out !== 3'd4 || overflow_out !== 1'b0 || frame_start_out !== 1'b1) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d of=%b fs=%b expected count=4 of=0 fs=1",
                     fifo_count_out, overflow_out, frame_start_out);
        end
        capture_frame(pl[0], pr[0], "full_order");
        for (int k = 1; k < 5; k++) begin
            wait_boundary("full_order_boundary");
            capture_frame(pl[k], pr[k], "full_order");
        end
        vectors++;
        if (underflow_out !== 1'b0 || fifo_count_out !== 3'd0) begin
            miscompares++;
            $display("FAIL after_full_drain: got uf=%b count=%0d expected uf=0 count=0", underflow_out, fifo_count_out);
        end
    endtask

    task automatic test_empty_simultaneous();
        go_pre_boundary("empty_simul_pos");
        push(16'h1357, 16'h2468);
        vectors++;
        if (underflow_out !== 1'b1 || fifo_count_out !== 3'd1) begin
            miscompares++;
            $display("FAIL empty_push_pop: got uf=%b count=%0d expected uf=1 count=1", underflow_out, fifo_count_out);
        end
        capture_frame(16'h0000, 16'h0000, "empty_simul_frame");
        wait_boundary("empty_simul_next");
        capture_frame(16'h1357, 16'h2468, "empty_simul_pushed");
    endtask

    task automatic test_timing();
        int   n, rises, lr_high;
        logic prev_bclk;
        wait_boundary("timing_start");
        n         = 0;
        rises     = 0;
        lr_high   = 0;
        prev_bclk = i2s_bclk_out;
        do begin
            step();
            n++;
            if (!prev_bclk && i2s_bclk_out) rises++;
            if (i2s_lrclk_out) lr_high++;
            prev_bclk = i2s_bclk_out;
        end while (!frame_start_out && n < 2000);
        vectors++;
        if (n != FRAME || rises != 64 || lr_high != FRAME / 2) begin
            miscompares++;
            $display("FAIL timing: got period=%0d rises=%0d lr_high=%0d expected %0d 64 %0d",
                     n, rises, lr_high, FRAME, FRAME / 2);
        end
        step();
        vectors++;
        if (frame_start_out !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_start_width: got %b one cycle after pulse, expected 0", frame_start_out);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        wait_boundary("midframe_setup");
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        n = 0;
        while (since_fs != 20 * 2 * BCLK_DIV + 15 && n < 2000) begin
            step();
            n++;
        end
        vectors++;
        if (fifo_count_out !== 3'd3 || i2s_bclk_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_pre: got count=%0d bclk=%b expected count=3 bclk=1", fifo_count_out, i2s_bclk_out);
        end
        rst_in = 1'b0;
        #1;
        vectors++;
        if ({i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out, underflow_out, overflow_out} !== 6'b0
            || fifo_count_out !== 3'd0) begin
            miscompares++;
            $display("FAIL midframe_reset: got outs=%b count=%0d expected 000000 count=0",
                     {i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out, underflow_out, overflow_out},
                     fifo_count_out);
        end
        repeat (3) step();
        rst_in = 1'b1;
        for (int c = 1; c <= 2 * BCLK_DIV; c++) begin
            step();
            if (c == 2 * BCLK_DIV - 1) begin
                vectors++;
                if (frame_start_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rerelease_early: got fs=%b expected 0", frame_start_out);
                end
            end
        end
        vectors++;
        if (frame_start_out !== 1'b1 || underflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rerelease_boundary: got fs=%b uf=%b expected 1 1", frame_start_out, underflow_out);
        end
        capture_frame(16'h0000, 16'h0000, "after_midframe_reset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_frame();
        test_underflow();
        test_clear_flags();
        test_overflow();
        test_full_simultaneous();
        test_empty_simultaneous();
        test_timing();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 12, meaning clk_in cycles per bclk half-period (bclk = 100 MHz/24 ≈ 4.17 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of stereo sample pairs buffered; power of two, minimum 2.
REQ-003 SHALL have port clk_in  input  1  system clock, 100 MHz; the only clock.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_valid_in  input  1  one-cycle pulse; left_in/right_in valid.
REQ-006 SHALL have port left_in  input  16  signed left sample (FIR speaker output).
REQ-007 SHALL have port right_in  input  16  signed right sample.
REQ-008 SHALL have port clear_flags_in  input  1  synchronous clear of sticky flags.
REQ-009 SHALL have port i2s_bclk_out  output  1  I2S bit clock to DAC.
REQ-010 SHALL have port i2s_lrclk_out  output  1  word select; 0 = left slot, period 64 bclk.
REQ-011 SHALL have port i2s_data_out  output  1  serial data, MSB first.
REQ-012 SHALL have port frame_start_out  output  1  one-cycle pulse at each frame boundary.
REQ-013 SHALL have port fifo_count_out  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-014 SHALL have port underflow_out  output  1  sticky; a frame started with the FIFO empty.
REQ-015 SHALL have port overflow_out  output  1  sticky; a push was dropped because the FIFO was full.

Function
REQ-016 SHALL generate the bit clock with a divider counter: bclk toggles when the counter reaches BCLK_DIV-1, and the counter then returns to 0; 50% duty cycle.
REQ-017 SHALL define "fall tick" as the clk_in cycle in which bclk goes 1->0; all of bit_cnt, lrclk, data and pop SHALL update only on fall ticks.
REQ-018 SHALL keep bit_cnt as 6 bits, incrementing on each fall tick and wrapping 63->0; a frame boundary is a fall tick on which bit_cnt becomes 0.
REQ-019 SHALL drive lrclk = 0 for bit_cnt 0..31 and lrclk = 1 for bit_cnt 32..63.
REQ-020 SHALL drive data for slot position p = bit_cnt mod 32 as follows: p = 1..16 gives sample bit [16-p] (left word in slot 0, right word in slot 1); p = 0 and p = 17..31 give 0. This is the standard I2S one-bclk delay.
REQ-021 SHALL pop one pair from the FIFO at each frame boundary and load it into the left and right shift registers; the popped pair is transmitted in that same frame.
REQ-022 SHALL, on a frame boundary with the FIFO empty, transmit 0 for both words and set underflow_out.
REQ-023 SHALL push {left_in, right_in} into the FIFO on sample_valid_in when the count is below FIFO_DEPTH; otherwise SHALL drop the pair and set overflow_out.
REQ-024 SHALL accept both operations on a simultaneous push and pop when the FIFO is full; the count is unchanged and there is no overflow.
REQ-025 SHALL, on a simultaneous push and pop when the FIFO is empty, treat the pop as an underflow and store the pushed pair; the count becomes 1.
REQ-026 SHALL use circular read/write pointers that wrap modulo FIFO_DEPTH; the order is strictly FIFO.
REQ-027 SHALL pulse frame_start_out high for exactly the clk_in cycle of each frame boundary.
REQ-028 SHALL make clear_flags_in clear both flags on the next cycle; a flag event in the same cycle as the clear wins, and the flag stays set.
REQ-029 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, while rst_in = 0, asynchronously force: bclk 0, lrclk 0, data 0, frame_start 0, divider 0, bit_cnt 63, FIFO empty (count 0, pointers 0), shift registers 0, both flags 0.
REQ-031 SHALL, after rst_in deasserts, produce the first bclk rise at cycle BCLK_DIV; the first fall tick, at cycle 2*BCLK_DIV, is a frame boundary.
REQ-032 SHALL, when reset is asserted mid-frame, abort the frame immediately; no partial word resumes after release.

Verification
REQ-033 Push L=16'hA5C3, R=16'h8001 before the first boundary -> first frame: data bits p=1..16 of slot 0 = A5C3 MSB-first, slot 1 = 8001; all other bits 0; lrclk low for 32 bclk, then high for 32.
REQ-034 No pushes after reset -> every frame transmits zeros, underflow_out=1 after the first boundary, fifo_count_out=0.
REQ-035 Five pushes (values 1..5) with no boundary in between, FIFO_DEPTH=4 -> count=4, overflow_out=1; frames then output 1,2,3,4 in order, and 5 is never sent.
REQ-036 Full FIFO with push and pop in the same cycle -> count stays 4, overflow_out stays 0; empty FIFO with push and pop in the same cycle -> underflow_out=1, count=1.
REQ-037 Measure timing -> bclk period = 24 cycles, lrclk period = 1536 cycles, frame_start_out pulse width = 1 cycle every 1536 cycles.
REQ-038 Assert rst_in low at bit_cnt=20 while the FIFO holds 3 entries -> outputs 0 immediately, count 0; after release, the first boundary is at cycle 24.
